sample_mul_share_arb: RTL

Round-robin arbiter that shares one 2-stage pipelined signed 11-bit multiplier between NUM_REQ requesters. Each requester presents operands through a valid/ready handshake. The arbiter issues at most one multiply per cycle and tags it with the requester index. It returns the product on a single result port with backpressure. The block sits between the HLS-generated compute loops and the shared DSP48 multiplier, replacing per-loop multiplier instances.

---
 rtl/sample_mul_pkg.sv | 21 ++
 rtl/sample_mul_pipe_core.sv | 34 +++
 rtl/sample_mul_share_arb.sv | 95 +++++++++
 3 files changed

// File: rtl/sample_mul_pkg.sv
// rtl/sample_mul_pkg.sv - shared widths, clog2 helper and the {valid, id} pipeline tag
package sample_mul_pkg;

  localparam int DATA_W_DEF = 11;
  localparam int ID_W_DEF   = 2;
  // Tag id is sized for the largest supported requester count (8).
  localparam int TAG_ID_W   = 3;

  function automatic int clog2(input int n);
    for (int r = 0; r < 32; r++) begin
      if ((1 << r) >= n) return r;
    end
    return 32;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } pipe_tag_t;

endpackage

// File: rtl/sample_mul_pipe_core.sv
// rtl/sample_mul_pipe_core.sv - 2-stage signed multiplier (operand regs, product reg), DSP48 friendly
module sample_mul_pipe_core
  import sample_mul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] p
);

  logic signed [DATA_W-1:0] a_q;
  logic signed [DATA_W-1:0] b_q;
  logic signed [DATA_W-1:0] p_q;
  logic                     ld;

  // Data regs carry no reset; they simply hold while reset is asserted.
  assign ld = ce & ~reset;

  // Low DATA_W bits of a product are the same for signed and unsigned operands.
  always_ff @(posedge clk) begin
    if (ld) begin
      a_q <= $signed(a);
      b_q <= $signed(b);
      p_q <= a_q * b_q;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/sample_mul_share_arb.sv
// rtl/sample_mul_share_arb.sv - round-robin share of one pipelined multiplier among NUM_REQ requesters
module sample_mul_share_arb
  import sample_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  output logic [ID_W-1:0]           res_id,
  output logic [DATA_W-1:0]         res_data,
  input  logic                      res_ready
);

  logic              adv;
  logic              found;
  logic              fire;
  logic [ID_W-1:0]   gnt;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] a_sel, b_sel;
  pipe_tag_t         tag1_q, tag2_q, tag1_d;
  logic              unused_tag_bits;

  // Scan farthest-to-nearest from last grant so the nearest valid requester wins.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ID_W'((int'(last) + i) % NUM_REQ);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    adv          = ~tag2_q.valid | res_ready;
    {found, gnt} = rr_pick(req_valid, ptr_q);
    fire         = found & adv & ~reset;
    req_ready    = '0;
    if (fire) req_ready[gnt] = 1'b1;
    ptr_d        = fire ? gnt : ptr_q;
    tag1_d.valid = fire;
    tag1_d.id    = fire ? TAG_ID_W'(gnt) : '0;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == ID_W'(i)) begin
        a_sel = req_a[i*DATA_W +: DATA_W];
        b_sel = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Tag shift register advances with the core so tags stay aligned to products.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= ID_W'(NUM_REQ - 1);
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (adv) begin
        tag1_q <= tag1_d;
        tag2_q <= tag1_q;
      end
    end
  end

  sample_mul_pipe_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .ce   (adv),
    .a    (a_sel),
    .b    (b_sel),
    .p    (res_data)
  );

  assign res_valid       = tag2_q.valid;
  assign res_id          = tag2_q.id[ID_W-1:0];
  assign unused_tag_bits = ^tag2_q.id;

endmodule
